// File: rtl/usb_host_tx_arbiter_pkg.sv
// Shared definitions for the USB host PHY TX arbiter.
//   arb_state_e  : arbiter FSM encodings (ARB_IDLE / ARB_OWN / ARB_GAP)
//   src_idx_e    : requester index map, index 0 is the highest-priority source
//   width_min1() : $clog2 clamped to at least one bit, used for counter sizing
package usb_host_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  typedef enum int unsigned {
    SRC_RESET    = 0,
    SRC_ENUM     = 1,
    SRC_XACT     = 2,
    SRC_SOF      = 3,
    SRC_TOKEN    = 4,
    SRC_PROTOCOL = 5
  } src_idx_e;

  function automatic int width_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/usb_host_tx_arbiter_pick.sv
// usb_arb_pick: combinational N_SRC-wide winner picker.
// Configuration macro: USB_ARB_RR_EN
//   defined   : rotating search starting at (last_idx + 1) mod N_SRC; the reset
//               controller (SRC_RESET) still wins outright whenever it is eligible.
//   undefined : strict fixed priority, lowest eligible index wins.
// Ports:
//   eligible   in  N_SRC  requesters allowed to win this cycle
//   last_idx   in  IW     index of the previous owner
//   winner     out N_SRC  one-hot winner, 0 when nothing eligible
//   winner_idx out IW     binary index of winner (0 when none)
module usb_arb_pick
  import usb_host_tx_arbiter_pkg::*;
#(
  parameter int N_SRC = 6,
  localparam int IW = width_min1(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [IW-1:0]    last_idx,
  output logic [N_SRC-1:0] winner,
  output logic [IW-1:0]    winner_idx
);

  logic found;

`ifdef USB_ARB_RR_EN
  // Two passes emulate a rotation: first the indices above the last owner,
  // then wrap around to the indices at or below it.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    if (eligible[SRC_RESET]) begin
      winner[SRC_RESET] = 1'b1;
      found             = 1'b1;
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && eligible[i] && (i > int'(last_idx))) begin
        winner[i]  = 1'b1;
        winner_idx = IW'(i);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && eligible[i] && (i <= int'(last_idx))) begin
        winner[i]  = 1'b1;
        winner_idx = IW'(i);
        found      = 1'b1;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last_idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && eligible[i]) begin
        winner[i]  = 1'b1;
        winner_idx = IW'(i);
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/usb_host_tx_arbiter.sv
// usb_host_tx_arbiter: N-source arbiter for the USB host PHY TX port with
// packet-level locking, TxReady backpressure, inter-packet gap and a
// stuck-owner watchdog.
// Configuration macro: USB_ARB_RR_EN (round-robin pick instead of fixed priority).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   src_tx_data         packed source bytes, source i at [i*DW +: DW]
//   src_tx_valid        per-source byte valid
//   src_active          per-source packet request / hold
//   src_tx_ready        per-source byte accepted (owner only, follows phy_tx_ready)
//   phy_tx_data/valid   to PHY, owner's data while owning, 0 otherwise
//   phy_tx_ready        PHY TxReady
//   grant               one-hot owner, 0 when none
//   busy                arbiter not idle
//   timeout_pulse       one cycle after a watchdog release
//
// state    | meaning
// ARB_IDLE | no owner; pick a winner among active, non-stuck sources
// ARB_OWN  | grant held, owner's stream forwarded to PHY
// ARB_GAP  | forced idle between packets, counts down from GAP_CYCLES-1
module usb_host_tx_arbiter
  import usb_host_tx_arbiter_pkg::*;
#(
  parameter int N_SRC      = 6,
  parameter int DW         = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC*DW-1:0] src_tx_data,
  input  logic [N_SRC-1:0]    src_tx_valid,
  input  logic [N_SRC-1:0]    src_active,
  output logic [N_SRC-1:0]    src_tx_ready,
  output logic [DW-1:0]       phy_tx_data,
  output logic                phy_tx_valid,
  input  logic                phy_tx_ready,
  output logic [N_SRC-1:0]    grant,
  output logic                busy,
  output logic                timeout_pulse
);

  localparam int IW  = width_min1(N_SRC);
  localparam int WDW = width_min1(TIMEOUT + 1);
  localparam int GPW = width_min1(GAP_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GPW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GPW'(GAP_CYCLES - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [N_SRC-1:0] stuck_q, stuck_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [GPW-1:0]   gap_q, gap_d;
  logic [IW-1:0]    last_q, last_d;
  logic             pulse_q, pulse_d;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] winner;
  logic [IW-1:0]    winner_idx;
  logic             owner_active;
  logic             owner_valid;
  logic [DW-1:0]    owner_data;

  assign eligible = src_active & ~stuck_q;

  usb_arb_pick #(.N_SRC(N_SRC)) u_pick (
    .eligible   (eligible),
    .last_idx   (last_q),
    .winner     (winner),
    .winner_idx (winner_idx)
  );

  // grant_q is zero outside ARB_OWN, so the owner mux naturally yields 0 there.
  assign owner_active = |(src_active & grant_q);
  assign owner_valid  = |(src_tx_valid & grant_q);

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) owner_data = owner_data | src_tx_data[i*DW +: DW];
    end
  end

  // A byte presented in the same cycle the owner drops active is discarded.
  assign phy_tx_data   = owner_data;
  assign phy_tx_valid  = owner_valid & owner_active;
  assign src_tx_ready  = grant_q & {N_SRC{phy_tx_ready}};
  assign grant         = grant_q;
  assign busy          = (state_q != ARB_IDLE);
  assign timeout_pulse = pulse_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    last_d  = last_q;
    pulse_d = 1'b0;
    stuck_d = stuck_q & src_active;
    unique case (state_q)
      ARB_IDLE: begin
        wd_d = '0;
        if (|eligible) begin
          grant_d = winner;
          last_d  = winner_idx;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (!owner_active) begin
          grant_d = '0;
          wd_d    = '0;
          gap_d   = GAP_LOAD;
          state_d = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
        end else if (owner_valid) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          grant_d = '0;
          wd_d    = '0;
          gap_d   = GAP_LOAD;
          pulse_d = 1'b1;
          stuck_d = stuck_d | grant_q;
          state_d = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ARB_GAP: begin
        if (gap_q == '0) state_d = ARB_IDLE;
        else             gap_d   = gap_q - GPW'(1);
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      stuck_q <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      last_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      stuck_q <= stuck_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: tb/tb_usb_host_tx_arbiter.sv
// Self-checking bench for usb_host_tx_arbiter: directed scenarios followed by
// randomized traffic; a packet-level reference model predicts every cycle's
// outputs into a scoreboard queue that a negedge monitor drains and compares.
module tb_usb_host_tx_arbiter;

  localparam int N   = 6;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] src_tx_data;
  logic [N-1:0]    src_tx_valid;
  logic [N-1:0]    src_active;
  logic [N-1:0]    src_tx_ready;
  logic [DW-1:0]   phy_tx_data;
  logic            phy_tx_valid;
  logic            phy_tx_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_pulse;

  always #5 clk = ~clk;

  usb_host_tx_arbiter #(.N_SRC(N), .DW(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_tx_data   (src_tx_data),
    .src_tx_valid  (src_tx_valid),
    .src_active    (src_active),
    .src_tx_ready  (src_tx_ready),
    .phy_tx_data   (phy_tx_data),
    .phy_tx_valid  (phy_tx_valid),
    .phy_tx_ready  (phy_tx_ready),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct {
    logic [N-1:0]  grant;
    logic [DW-1:0] data;
    logic          valid;
    logic [N-1:0]  ready;
    logic          busy;
    logic          pulse;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [DW-1:0] dat [N];

  // Reference model: who owns the bus, how many forced-idle cycles remain,
  // how long the owner has been silent, and which sources are locked out.
  int m_owner;
  int m_gap;
  int m_stall;
  int m_last;
  bit m_pulse;
  bit m_stuck [N];
  bit m_known = 1'b0;

  function automatic int ref_pick(input logic [N-1:0] elig, input int last);
`ifdef USB_ARB_RR_EN
    if (elig[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      if (elig[(last + k) % N]) return (last + k) % N;
    end
    return -1;
`else
    for (int i = 0; i < N; i++) if (elig[i]) return i;
    return -1;
`endif
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_stall = 0;
    m_last  = 0;
    m_pulse = 1'b0;
    for (int i = 0; i < N; i++) m_stuck[i] = 1'b0;
  endtask

  // Called one time unit after a rising edge: applies inputs, predicts the
  // outputs of this cycle, then advances the model across the next edge.
  task automatic step();
    exp_t e;
    logic [N-1:0] elig;
    int w;
    int stuck_set;
    bit new_pulse;
    for (int i = 0; i < N; i++) src_tx_data[i*DW +: DW] = dat[i];
    if (m_known) begin
      if (m_owner >= 0) begin
        e.grant = N'(1) << m_owner;
        e.data  = dat[m_owner];
        e.valid = src_active[m_owner] && src_tx_valid[m_owner];
        e.ready = phy_tx_ready ? (N'(1) << m_owner) : '0;
        e.busy  = 1'b1;
      end else begin
        e.grant = '0;
        e.data  = '0;
        e.valid = 1'b0;
        e.ready = '0;
        e.busy  = (m_gap > 0);
      end
      e.pulse = m_pulse;
      e.cyc   = cyc;
      sb_q.push_back(e);
    end
    if (!rst_n) begin
      model_reset();
      m_known = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) elig[i] = src_active[i] && !m_stuck[i];
      stuck_set = -1;
      new_pulse = 1'b0;
      if (m_owner >= 0) begin
        if (!src_active[m_owner]) begin
          m_owner = -1;
          m_gap   = GAP;
          m_stall = 0;
        end else if (src_tx_valid[m_owner]) begin
          m_stall = 0;
        end else begin
          m_stall++;
          if (m_stall == TO) begin
            stuck_set = m_owner;
            new_pulse = 1'b1;
            m_owner   = -1;
            m_gap     = GAP;
            m_stall   = 0;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        w = ref_pick(elig, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
        end
      end
      for (int i = 0; i < N; i++) if (!src_active[i]) m_stuck[i] = 1'b0;
      if (stuck_set >= 0) m_stuck[stuck_set] = 1'b1;
      m_pulse = new_pulse;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (grant !== e.grant || phy_tx_data !== e.data || phy_tx_valid !== e.valid ||
          src_tx_ready !== e.ready || busy !== e.busy || timeout_pulse !== e.pulse) begin
        n_bad++;
        $display("FAIL cycle_outputs cyc=%0d got grant=%b data=%h valid=%b ready=%b busy=%b pulse=%b want grant=%b data=%h valid=%b ready=%b busy=%b pulse=%b",
                 e.cyc, grant, phy_tx_data, phy_tx_valid, src_tx_ready, busy, timeout_pulse,
                 e.grant, e.data, e.valid, e.ready, e.busy, e.pulse);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  bit silent [N];
  int prev_own;

  initial begin
    rst_n        = 1'b0;
    src_active   = '0;
    src_tx_valid = '0;
    phy_tx_ready = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = '0;
    model_reset();
    steps(2);
    rst_n = 1'b1;
    steps(2);

    // Src5 alone, then src0 arrives mid-packet and waits for gap + idle.
    src_active[5] = 1'b1; src_tx_valid[5] = 1'b1; dat[5] = 8'hAA;
    steps(3);
    src_active[0] = 1'b1; src_tx_valid[0] = 1'b1; dat[0] = 8'hFF;
    steps(3);
    src_active[5] = 1'b0; src_tx_valid[5] = 1'b0;
    steps(6);
    src_active[0] = 1'b0; src_tx_valid[0] = 1'b0;
    steps(4);

    // Backpressure during a src2 packet.
    src_active[2] = 1'b1; src_tx_valid[2] = 1'b1; dat[2] = 8'h5C;
    steps(2);
    phy_tx_ready = 1'b0;
    steps(3);
    phy_tx_ready = 1'b1;
    steps(2);
    src_active[2] = 1'b0; src_tx_valid[2] = 1'b0;
    steps(4);

    // Silent owner triggers the watchdog, stays locked out until active toggles.
    src_active[3] = 1'b1; dat[3] = 8'h33;
    steps(26);
    src_active[3] = 1'b0;
    steps(1);
    src_active[3] = 1'b1;
    steps(4);
    src_active[3] = 1'b0;
    steps(4);

    // Byte dropped when owner releases active while still valid.
    src_active[4] = 1'b1; src_tx_valid[4] = 1'b1; dat[4] = 8'h44;
    steps(3);
    src_active[4] = 1'b0;
    steps(1);
    src_tx_valid[4] = 1'b0;
    steps(4);

    // Sources 2..4 streaming one-byte packets; src0 joins midway.
    src_tx_valid = 6'b011101;
    dat[2] = 8'h22; dat[3] = 8'h23; dat[4] = 8'h24; dat[0] = 8'h20;
    prev_own = -1;
    for (int c = 0; c < 50; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i == 2 || i == 3 || i == 4 || (i == 0 && c >= 20 && c < 30))
          src_active[i] = !(m_owner == i && prev_own == i);
        else
          src_active[i] = 1'b0;
      end
      prev_own = m_owner;
      step();
    end
    src_active = '0; src_tx_valid = '0;
    steps(5);

    // Reset mid-packet.
    src_active[1] = 1'b1; src_tx_valid[1] = 1'b1; dat[1] = 8'h11;
    steps(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    steps(4);
    src_active[1] = 1'b0; src_tx_valid[1] = 1'b0;
    steps(4);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        for (int i = 0; i < N; i++) silent[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (src_active[i])
          src_active[i] = silent[i] ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 9) != 0);
        else
          src_active[i] = ($urandom_range(0, 4) == 0);
        src_tx_valid[i] = silent[i] ? 1'b0 : ($urandom_range(0, 9) < 7);
        dat[i] = DW'($urandom);
      end
      phy_tx_ready = ($urandom_range(0, 4) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    src_active = '0; src_tx_valid = '0;
    steps(4);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
